// File: rtl/trojan0_timer_pkg.sv
// Shared types and legality helpers for the Trojan0 multi-channel timer host.
package trojan0_timer_pkg;

    // Channel FSM encoding; values are visible in waveforms so keep them fixed.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2,
        StOvf     = 2'd3
    } ch_state_e;

    localparam int unsigned KeyWidth  = 128;
    localparam int unsigned LoadWidth = 64;

    function automatic bit tw_legal(input int unsigned tw);
        return (tw >= 8) && (tw <= 64);
    endfunction

    function automatic bit num_ch_legal(input int unsigned n);
        return (n >= 1) && (n <= 8);
    endfunction

endpackage

// File: rtl/trojan0_multitimer_host_if.sv
// Control/status bundle between the timer host and whatever drives it.
interface trojan0_multitimer_host_if #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned TIMER_WIDTH = 32
);
    logic [NUM_CH*TIMER_WIDTH-1:0] timer_load;
    logic [NUM_CH-1:0]             timer_start;
    logic [NUM_CH-1:0]             timer_stop;
    logic [NUM_CH-1:0]             timer_pause;
    logic [NUM_CH-1:0]             timer_reload;
    logic [NUM_CH-1:0]             irq_mask;
    logic [NUM_CH-1:0]             irq_clear;
    logic [NUM_CH*TIMER_WIDTH-1:0] timer_value;
    logic [NUM_CH-1:0]             timer_overflow;
    logic [NUM_CH-1:0]             timer_match;
    logic [NUM_CH-1:0]             timer_active;
    logic [NUM_CH-1:0]             status_ovf;
    logic [NUM_CH-1:0]             status_match;
    logic                          irq;

    modport master (
        output timer_load, timer_start, timer_stop, timer_pause, timer_reload,
        output irq_mask, irq_clear,
        input  timer_value, timer_overflow, timer_match, timer_active,
        input  status_ovf, status_match, irq
    );

    modport slave (
        input  timer_load, timer_start, timer_stop, timer_pause, timer_reload,
        input  irq_mask, irq_clear,
        output timer_value, timer_overflow, timer_match, timer_active,
        output status_ovf, status_match, irq
    );
endinterface

// File: rtl/trojan0.sv
// Trojan0 payload: folds the 128-bit key into the 64-bit perturbation word.
module trojan0 (
    input  logic [127:0] key,
    output logic [63:0]  load
);
    assign load = key[127:64] ^ key[63:0];
endmodule

// File: rtl/trojan0_timer_channel.sv
// One timer channel: FSM, counter, match/reload values, pulses and sticky flags.
module trojan0_timer_channel
    import trojan0_timer_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   pause,
    input  logic                   reload,
    input  logic                   irq_clear,
    input  logic [TIMER_WIDTH-1:0] load,
    input  logic [TIMER_WIDTH-1:0] match_xor,
    output logic [TIMER_WIDTH-1:0] value,
    output logic                   ovf_pulse,
    output logic                   match_pulse,
    output logic                   active,
    output logic                   running,
    output logic                   status_ovf,
    output logic                   status_match,
    output logic                   start_accept,
    output logic                   ovf_event
);
    ch_state_e              state_q, state_d;
    logic [TIMER_WIDTH-1:0] cnt_q, cnt_d, reload_q, reload_d, match_q, match_d, cnt_inc;
    logic                   mode_q, mode_d, match_event;
    logic                   ovf_pulse_q, match_pulse_q, sovf_q, smatch_q;

    // Next state and counter; priority is stop > start > pause > tick.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        reload_d     = reload_q;
        match_d      = match_q;
        mode_d       = mode_q;
        start_accept = 1'b0;
        ovf_event    = 1'b0;
        match_event  = 1'b0;
        cnt_inc      = cnt_q + TIMER_WIDTH'(1);
        unique case (state_q)
            StIdle: begin
                if (!stop && start) start_accept = 1'b1;
            end
            StRunning: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (start) begin
                    start_accept = 1'b1;
                end else if (pause) begin
                    state_d = StPaused;
                end else if (tick) begin
                    if (&cnt_q) begin
                        ovf_event = 1'b1;
                        if (mode_q) begin
                            cnt_d = reload_q;
                        end else begin
                            cnt_d   = '0;
                            state_d = StOvf;
                        end
                    end else begin
                        cnt_d       = cnt_inc;
                        match_event = (cnt_inc == match_q);
                    end
                end
            end
            StPaused: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (start) begin
                    start_accept = 1'b1;
                end else if (!pause) begin
                    state_d = StRunning;
                end
            end
            StOvf: begin
                // Start is deliberately ignored here.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (start_accept) begin
            state_d  = StRunning;
            cnt_d    = load;
            reload_d = load;
            match_d  = load ^ match_xor;
            mode_d   = reload;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            reload_q <= '0;
            match_q  <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            match_q  <= match_d;
            mode_q   <= mode_d;
        end
    end

    // One-cycle pulses and sticky flags; a new event beats irq_clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_pulse_q   <= 1'b0;
            match_pulse_q <= 1'b0;
            sovf_q        <= 1'b0;
            smatch_q      <= 1'b0;
        end else begin
            ovf_pulse_q   <= ovf_event;
            match_pulse_q <= match_event;
            sovf_q        <= ovf_event | (sovf_q & ~irq_clear);
            smatch_q      <= match_event | (smatch_q & ~irq_clear);
        end
    end

    assign value        = cnt_q;
    assign ovf_pulse    = ovf_pulse_q;
    assign match_pulse  = match_pulse_q;
    assign status_ovf   = sovf_q;
    assign status_match = smatch_q;
    assign running      = (state_q == StRunning);
    assign active       = (state_q == StRunning) || (state_q == StPaused);
endmodule

// File: rtl/trojan0_multitimer_host.sv
// Multi-channel timer host: shared prescaler, key register, irq and Trojan0 instance.
module trojan0_multitimer_host
    import trojan0_timer_pkg::*;
#(
    parameter int unsigned   NUM_CH      = 4,
    parameter int unsigned   TIMER_WIDTH = 32,
    parameter int unsigned   PRESCALER   = 1000,
    parameter logic [127:0]  KEY_INIT    = 128'hF1EE70123456789ABCDEFF1EE7012444
) (
    input logic                        clk,
    input logic                        rst,
    trojan0_multitimer_host_if.slave   bus
);
    if (!tw_legal(TIMER_WIDTH)) begin : g_bad_tw
        $error("TIMER_WIDTH must be within 8..64");
    end
    if (!num_ch_legal(NUM_CH)) begin : g_bad_ch
        $error("NUM_CH must be within 1..8");
    end

    localparam logic [15:0] PrescLast = 16'(PRESCALER - 1);

    logic [15:0]                   presc_q, presc_d;
    logic                          any_running, tick;
    logic [NUM_CH-1:0]             running, start_acc, ovf_evt, sovf, smatch;
    logic [NUM_CH-1:0]             ovf_pulse, match_pulse, active;
    logic [NUM_CH*TIMER_WIDTH-1:0] value_all;
    logic [KeyWidth-1:0]           key_q, key_d;
    logic [LoadWidth-1:0]          trojan_load;
    logic [31:0]                   key_mix;
    logic                          irq_q, irq_d;
    logic                          unused_load_bits;

    assign any_running = |running;
    assign tick        = any_running && (presc_q == 16'd0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        trojan0_timer_channel #(
            .TIMER_WIDTH(TIMER_WIDTH)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .start       (bus.timer_start[i]),
            .stop        (bus.timer_stop[i]),
            .pause       (bus.timer_pause[i]),
            .reload      (bus.timer_reload[i]),
            .irq_clear   (bus.irq_clear[i]),
            .load        (bus.timer_load[i*TIMER_WIDTH +: TIMER_WIDTH]),
            .match_xor   (trojan_load[TIMER_WIDTH-1:0]),
            .value       (value_all[i*TIMER_WIDTH +: TIMER_WIDTH]),
            .ovf_pulse   (ovf_pulse[i]),
            .match_pulse (match_pulse[i]),
            .active      (active[i]),
            .running     (running[i]),
            .status_ovf  (sovf[i]),
            .status_match(smatch[i]),
            .start_accept(start_acc[i]),
            .ovf_event   (ovf_evt[i])
        );
    end

    trojan0 u_trojan0 (
        .key (key_q),
        .load(trojan_load)
    );

    // Only the low TIMER_WIDTH bits perturb match values.
    assign unused_load_bits = ^trojan_load;

    // Prescaler advances only while some channel runs, otherwise holds.
    always_comb begin
        presc_d = presc_q;
        if (any_running) presc_d = (presc_q == PrescLast) ? 16'd0 : presc_q + 16'd1;
    end

    // Key rotates in ch0's counter on any accepted start or overflow, once per cycle.
    always_comb begin
        key_mix = 32'(value_all[TIMER_WIDTH-1:0]);
        key_d   = key_q;
        if ((|start_acc) || (|ovf_evt)) key_d = {key_q[95:0], key_q[127:96] ^ key_mix};
        irq_d = |((sovf | smatch) & bus.irq_mask);
    end

    // Host-level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= 16'd0;
            key_q   <= KEY_INIT;
            irq_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            key_q   <= key_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.timer_value    = value_all;
    assign bus.timer_overflow = ovf_pulse;
    assign bus.timer_match    = match_pulse;
    assign bus.timer_active   = active;
    assign bus.status_ovf     = sovf;
    assign bus.status_match   = smatch;
    assign bus.irq            = irq_q;
endmodule

// File: tb/tb_trojan0_multitimer_host.sv
// Self-checking bench for trojan0_multitimer_host (2 channels, 8-bit, prescaler 4).
module tb_trojan0_multitimer_host;
    localparam logic [127:0] KEY_INIT = 128'hF1EE70123456789ABCDEFF1EE7012444;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    trojan0_multitimer_host_if #(.NUM_CH(2), .TIMER_WIDTH(8)) bus ();

    trojan0_multitimer_host #(
        .NUM_CH     (2),
        .TIMER_WIDTH(8),
        .PRESCALER  (4),
        .KEY_INIT   (KEY_INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       start;
        logic       stop;
        logic       pause;
        logic       reload;
        logic       clear;
        logic [7:0] load;
        int         extra;
        logic [7:0] exp_val;
        logic       exp_act;
        logic       exp_ovf;
        logic       exp_sovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.timer_load   = '0;
        bus.timer_start  = '0;
        bus.timer_stop   = '0;
        bus.timer_pause  = '0;
        bus.timer_reload = '0;
        bus.irq_mask     = '0;
        bus.irq_clear    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // kind: 0 overflow[ch], 1 match[ch], 2 value0 == v, 3 value0 != v. Steps at least once.
    task automatic wait_for(input int kind, input int ch, input logic [7:0] v,
                            input int bound, output int n);
        logic hit;
        n = 0;
        do begin
            step();
            n++;
            case (kind)
                0:       hit = bus.timer_overflow[ch];
                1:       hit = bus.timer_match[ch];
                2:       hit = (bus.timer_value[7:0] == v);
                default: hit = (bus.timer_value[7:0] != v);
            endcase
        end while (!hit && n < bound);
        if (!hit) n = bound;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [63:0] tl;
        logic [7:0]  m;
        logic [127:0] k;

        // start, stop, pause, reload, clear, load, extra, val, act, ovf, sovf
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFD, 0, 8'hFD, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 0, 8'h20, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 0, 8'h20, 1'b0, 1'b0, 1'b0};

        idle_inputs();
        step();
        check("reset value", bus.timer_value, 16'h0000);
        check("reset active", bus.timer_active, 2'b00);
        check("reset irq", bus.irq, 1'b0);

        // One-shot overflow, OVF-state start ignored, clear, stop-beats-start.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.timer_start[0]   = vecs[i].start;
            bus.timer_stop[0]    = vecs[i].stop;
            bus.timer_pause[0]   = vecs[i].pause;
            bus.timer_reload[0]  = vecs[i].reload;
            bus.irq_clear[0]     = vecs[i].clear;
            bus.timer_load[7:0]  = vecs[i].load;
            step();
            bus.timer_start[0] = 1'b0;
            bus.timer_stop[0]  = 1'b0;
            bus.irq_clear[0]   = 1'b0;
            for (int j = 0; j < vecs[i].extra; j++) step();
            check($sformatf("vec%0d value", i), bus.timer_value[7:0], vecs[i].exp_val);
            check($sformatf("vec%0d active", i), bus.timer_active[0], vecs[i].exp_act);
            check($sformatf("vec%0d ovf", i), bus.timer_overflow[0], vecs[i].exp_ovf);
            check($sformatf("vec%0d sovf", i), bus.status_ovf[0], vecs[i].exp_sovf);
        end

        // Auto-reload on ch1: overflow every 2 ticks (8 cycles), stays active.
        do_reset();
        bus.timer_start[1]   = 1'b1;
        bus.timer_reload[1]  = 1'b1;
        bus.timer_load[15:8] = 8'hFE;
        step();
        bus.timer_start[1] = 1'b0;
        wait_for(0, 1, 8'h00, 50, n);
        check("ar first ovf within bound", n < 50, 1'b1);
        for (int r = 0; r < 2; r++) begin
            check($sformatf("ar%0d value", r), bus.timer_value[15:8], 8'hFE);
            check($sformatf("ar%0d active", r), bus.timer_active[1], 1'b1);
            check($sformatf("ar%0d sovf", r), bus.status_ovf[1], 1'b1);
            wait_for(0, 1, 8'h00, 50, n);
            check($sformatf("ar%0d period", r), n, 8);
        end

        // Match on ch0: M = load ^ Trojan0 load derived from the reset key.
        do_reset();
        k  = KEY_INIT;
        tl = k[127:64] ^ k[63:0];
        m  = 8'h10 ^ tl[7:0];
        bus.irq_mask        = 2'b01;
        bus.timer_start[0]  = 1'b1;
        bus.timer_load[7:0] = 8'h10;
        step();
        bus.timer_start[0] = 1'b0;
        wait_for(1, 0, 8'h00, 1000, n);
        check("match within bound", n < 1000, 1'b1);
        check("match value", bus.timer_value[7:0], m);
        check("match sticky", bus.status_match[0], 1'b1);
        check("match irq lags", bus.irq, 1'b0);
        step();
        check("match pulse one cycle", bus.timer_match[0], 1'b0);
        check("match irq", bus.irq, 1'b1);
        bus.irq_mask = 2'b00;
        step();
        check("masked irq", bus.irq, 1'b0);

        // Pause freezes the count, release resumes, stop beats start.
        do_reset();
        bus.timer_start[0]  = 1'b1;
        bus.timer_load[7:0] = 8'h40;
        step();
        bus.timer_start[0] = 1'b0;
        wait_for(2, 0, 8'h45, 100, n);
        check("pause reach 45", bus.timer_value[7:0], 8'h45);
        bus.timer_pause[0] = 1'b1;
        for (int j = 0; j < 21; j++) step();
        check("paused value", bus.timer_value[7:0], 8'h45);
        check("paused active", bus.timer_active[0], 1'b1);
        bus.timer_pause[0] = 1'b0;
        step();
        check("release value", bus.timer_value[7:0], 8'h45);
        wait_for(3, 0, 8'h45, 20, n);
        check("resume value", bus.timer_value[7:0], 8'h46);
        bus.timer_start[0] = 1'b1;
        bus.timer_stop[0]  = 1'b1;
        step();
        bus.timer_start[0] = 1'b0;
        bus.timer_stop[0]  = 1'b0;
        check("stop+start active", bus.timer_active[0], 1'b0);
        check("stop+start held", bus.timer_value[7:0], 8'h46);

        // irq_clear coincident with overflow loses; clear alone wins.
        do_reset();
        bus.irq_mask        = 2'b01;
        bus.timer_start[0]  = 1'b1;
        bus.timer_reload[0] = 1'b1;
        bus.timer_load[7:0] = 8'hFE;
        step();
        bus.timer_start[0] = 1'b0;
        wait_for(0, 0, 8'h00, 50, n);
        check("clr first ovf", bus.timer_overflow[0], 1'b1);
        for (int j = 0; j < 7; j++) step();
        bus.irq_clear[0] = 1'b1;
        step();
        check("clr coincident ovf", bus.timer_overflow[0], 1'b1);
        check("clr set wins", bus.status_ovf[0], 1'b1);
        step();
        bus.irq_clear[0] = 1'b0;
        check("clr alone", bus.status_ovf[0], 1'b0);
        check("clr irq still high", bus.irq, 1'b1);
        step();
        check("clr irq drops", bus.irq, 1'b0);

        // Asynchronous reset mid-count with both channels running.
        do_reset();
        bus.timer_start      = 2'b11;
        bus.timer_load       = 16'h2010;
        step();
        bus.timer_start = 2'b00;
        for (int j = 0; j < 6; j++) step();
        check("pre-rst active", bus.timer_active, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check("arst value", bus.timer_value, 16'h0000);
        check("arst active", bus.timer_active, 2'b00);
        check("arst status", {bus.status_ovf, bus.status_match}, 4'h0);
        check("arst pulses", {bus.timer_overflow, bus.timer_match}, 4'h0);
        check("arst irq", bus.irq, 1'b0);
        step();
        rst = 1'b0;
        step();
        check("key after reset", dut.key_q, KEY_INIT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
